// File: rtl/pla_trainer.sv
// Sequential perceptron trainer: buffers labelled samples, then runs epochs of the
// perceptron rule one sample per cycle and presents the W1/W2 pair for the classifier.
module pla_trainer #(
   parameter int XW        = 3,
   parameter int WW        = 8,
   parameter int DEPTH     = 10,
   parameter int MAX_EPOCH = 15,
   parameter int INIT_W    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] in_x1,
   input  logic [XW-1:0] in_x2,
   input  logic          in_t,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          converged,
   output logic [3:0]    epoch_cnt,
   output logic [WW-1:0] W1,
   output logic [WW-1:0] W2
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = 2 * XW + 1;

   typedef enum logic [1:0] {LOAD, TRAIN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   logic [CW-1:0] index_reg, index_next;
   logic [3:0]    epoch_reg, epoch_next;
   logic          err_reg, err_next;
   logic          conv_reg, conv_next;
   logic [WW-1:0] w1_reg, w1_next;
   logic [WW-1:0] w2_reg, w2_next;
   logic          wr_en;

   logic [SW-1:0] buf_mem [DEPTH];
   logic [SW-1:0] cur;
   logic [WW-1:0] x1_ext, x2_ext, sum;
   logic          cur_t, y, mis;
   logic [3:0]    epoch_inc;

   always_ff @(posedge clk) begin
      if (wr_en)
         buf_mem[count_reg] <= {in_x1, in_x2, in_t};
   end

   // Small buffer read combinationally so each TRAIN cycle sees the weights
   // updated by the previous sample.
   assign cur    = buf_mem[index_reg];
   assign x1_ext = WW'(cur[SW-1 -: XW]);
   assign x2_ext = WW'(cur[XW:1]);
   assign cur_t  = cur[0];

   // Same arithmetic as the classifier: sums above 2^(WW-1)-1 classify as y=0.
   assign sum       = (w1_reg * x1_ext) + (w2_reg * x2_ext);
   assign y         = ~sum[WW-1];
   assign mis       = (y != cur_t);
   assign epoch_inc = epoch_reg + 4'd1;

   assign in_ready  = (state_reg == LOAD) && (count_reg < CW'(DEPTH));
   assign busy      = (state_reg == TRAIN);
   assign done      = (state_reg == DONE);
   assign converged = conv_reg;
   assign epoch_cnt = epoch_reg;
   assign W1        = w1_reg;
   assign W2        = w2_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= LOAD;
         count_reg <= '0;
         index_reg <= '0;
         epoch_reg <= '0;
         err_reg   <= 1'b0;
         conv_reg  <= 1'b0;
         w1_reg    <= WW'(INIT_W);
         w2_reg    <= WW'(INIT_W);
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         index_reg <= index_next;
         epoch_reg <= epoch_next;
         err_reg   <= err_next;
         conv_reg  <= conv_next;
         w1_reg    <= w1_next;
         w2_reg    <= w2_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      index_next = index_reg;
      epoch_next = epoch_reg;
      err_next   = err_reg;
      conv_next  = conv_reg;
      w1_next    = w1_reg;
      w2_next    = w2_reg;
      wr_en      = 1'b0;
      case (state_reg)
         LOAD: begin
            if (in_valid && in_ready) begin
               wr_en      = 1'b1;
               count_next = count_reg + CW'(1);
            end
            // A sample accepted in the start cycle is part of the training set.
            if (start && (count_next != '0)) begin
               state_next = TRAIN;
               w1_next    = WW'(INIT_W);
               w2_next    = WW'(INIT_W);
               index_next = '0;
               epoch_next = '0;
               err_next   = 1'b0;
            end
         end
         TRAIN: begin
            if (mis) begin
               err_next = 1'b1;
               if (cur_t) begin
                  w1_next = w1_reg + x1_ext;
                  w2_next = w2_reg + x2_ext;
               end else begin
                  w1_next = w1_reg - x1_ext;
                  w2_next = w2_reg - x2_ext;
               end
            end
            if (index_reg == count_reg - CW'(1)) begin
               epoch_next = epoch_inc;
               if (!(err_reg || mis)) begin
                  conv_next  = 1'b1;
                  state_next = DONE;
               end else if (epoch_inc == 4'(MAX_EPOCH)) begin
                  conv_next  = 1'b0;
                  state_next = DONE;
               end else begin
                  index_next = '0;
                  err_next   = 1'b0;
               end
            end else begin
               index_next = index_reg + CW'(1);
            end
         end
         DONE: begin
            if (start) begin
               state_next = LOAD;
               count_next = '0;
               conv_next  = 1'b0;
            end
         end
         default: state_next = LOAD;
      endcase
   end

endmodule

// File: tb/tb_pla_trainer.sv
// Scoreboard bench for pla_trainer: expected training results are queued at start
// and compared when the trainer reaches DONE.
module tb_pla_trainer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_t = 1'b0;
   logic       start = 1'b0;
   logic [2:0] in_x1 = '0;
   logic [2:0] in_x2 = '0;
   logic       in_ready, busy, done, converged;
   logic [3:0] epoch_cnt;
   logic [7:0] W1, W2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] w1;
      logic [7:0] w2;
      logic       conv;
      logic [3:0] ep;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] qx1[$];
   logic [2:0] qx2[$];
   logic       qt[$];

   always #5 clk = ~clk;

   pla_trainer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x1(in_x1), .in_x2(in_x2), .in_t(in_t), .start(start),
      .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt),
      .W1(W1), .W2(W2)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic classify(input logic [7:0] w1, input logic [7:0] w2,
                                     input logic [2:0] x1, input logic [2:0] x2);
      logic [7:0] s;
      s = w1 * {5'b0, x1} + w2 * {5'b0, x2};
      return (s > 8'd127) ? 1'b0 : 1'b1;
   endfunction

   function automatic exp_t model_run();
      exp_t       e;
      logic [7:0] w1 = 8'd1;
      logic [7:0] w2 = 8'd1;
      bit         err;
      int         ep = 0;
      int         cyc = 0;
      do begin
         err = 1'b0;
         for (int i = 0; i < qx1.size(); i++) begin
            cyc++;
            if (classify(w1, w2, qx1[i], qx2[i]) != qt[i]) begin
               err = 1'b1;
               if (qt[i]) begin
                  w1 = w1 + {5'b0, qx1[i]};
                  w2 = w2 + {5'b0, qx2[i]};
               end else begin
                  w1 = w1 - {5'b0, qx1[i]};
                  w2 = w2 - {5'b0, qx2[i]};
               end
            end
         end
         ep++;
      end while (err && ep < 15);
      e.w1 = w1; e.w2 = w2; e.conv = !err; e.ep = 4'(ep); e.cyc = cyc;
      return e;
   endfunction

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send(input logic [2:0] a, input logic [2:0] b, input logic t);
      int n = 0;
      in_valid = 1'b1; in_x1 = a; in_x2 = b; in_t = t;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 50) begin
         fails++;
         $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
      end else begin
         qx1.push_back(a); qx2.push_back(b); qt.push_back(t);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic start_train(input bit use_model, input exp_t given, input bit push);
      if (push) sb.push_back(use_model ? model_run() : given);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain_result(input string name);
      int   n = 0;
      exp_t e;
      while (busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         tests++; fails++;
         $display("FAIL %s_scoreboard: queue empty, required one entry", name);
         return;
      end
      e = sb.pop_front();
      $display("[TB] %s: cycles=%0d W1=%0d W2=%0d conv=%0b epochs=%0d", name, n, W1, W2,
               converged, epoch_cnt);
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL %s_done: got %0b required 1", name, done); end
      tests++;
      if (n != e.cyc) begin fails++; $display("FAIL %s_cycles: got %0d required %0d", name, n, e.cyc); end
      tests++;
      if (W1 !== e.w1) begin fails++; $display("FAIL %s_w1: got %0d required %0d", name, W1, e.w1); end
      tests++;
      if (W2 !== e.w2) begin fails++; $display("FAIL %s_w2: got %0d required %0d", name, W2, e.w2); end
      tests++;
      if (converged !== e.conv) begin
         fails++; $display("FAIL %s_conv: got %0b required %0b", name, converged, e.conv);
      end
      tests++;
      if (epoch_cnt !== e.ep) begin
         fails++; $display("FAIL %s_epochs: got %0d required %0d", name, epoch_cnt, e.ep);
      end
      if (converged === 1'b1) begin
         for (int i = 0; i < qx1.size(); i++) begin
            tests++;
            if (classify(W1, W2, qx1[i], qx2[i]) !== qt[i]) begin
               fails++;
               $display("FAIL %s_classify[%0d]: y=%0b required %0b", name, i,
                        classify(W1, W2, qx1[i], qx2[i]), qt[i]);
            end
         end
      end
   endtask

   task automatic return_to_load();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      qx1.delete(); qx2.delete(); qt.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tests++;
      if ({busy, done, converged} !== 3'b000) begin
         fails++; $display("FAIL reset_flags: busy/done/conv=%b required 000", {busy, done, converged});
      end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b required 1", in_ready); end
      tests++;
      if ({W1, W2} !== {8'd1, 8'd1}) begin
         fails++; $display("FAIL reset_weights: W1=%0d W2=%0d required 1 1", W1, W2);
      end
      tests++;
      if (epoch_cnt !== 4'd0) begin fails++; $display("FAIL reset_epoch: got %0d required 0", epoch_cnt); end
   endtask

   task automatic test_converge();
      send(3'd0, 3'd2, 1'b1);
      send(3'd2, 3'd0, 1'b0);
      start_train(1'b0, '{w1: 8'd255, w2: 8'd1, conv: 1'b1, ep: 4'd2, cyc: 4}, 1'b1);
      drain_result("converge");
      return_to_load();
      tests++;
      if ({done, converged, busy, in_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL clear_flags: done/conv/busy/ready=%b required 0001",
                  {done, converged, busy, in_ready});
      end
      tests++;
      if ({W1, W2} !== {8'd255, 8'd1}) begin
         fails++; $display("FAIL clear_weights_hold: W1=%0d W2=%0d required 255 1", W1, W2);
      end
   endtask

   task automatic test_nonseparable();
      send(3'd1, 3'd1, 1'b1);
      send(3'd1, 3'd1, 1'b0);
      start_train(1'b0, '{w1: 8'd255, w2: 8'd255, conv: 1'b0, ep: 4'd15, cyc: 30}, 1'b1);
      drain_result("nonsep");
      return_to_load();
   endtask

   task automatic test_full_buffer();
      exp_t dummy = '{w1: 8'd0, w2: 8'd0, conv: 1'b0, ep: 4'd0, cyc: 0};
      for (int i = 0; i < 10; i++)
         send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      in_valid = 1'b1; in_x1 = 3'd5; in_x2 = 3'd3; in_t = 1'b1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0b required 0", in_ready); end
      repeat (2) @(negedge clk);
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL full_hold: got %0b required 0", in_ready); end
      start_train(1'b1, dummy, 1'b1);
      drain_result("full");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      qx1.delete(); qx2.delete(); qt.delete();
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL pending_ready: got %0b required 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      qx1.push_back(3'd5); qx2.push_back(3'd3); qt.push_back(1'b1);
      start_train(1'b1, dummy, 1'b1);
      drain_result("eleventh");
      return_to_load();
   endtask

   task automatic test_start_empty();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({busy, done, in_ready} !== 3'b001) begin
         fails++; $display("FAIL empty_start: busy/done/ready=%b required 001", {busy, done, in_ready});
      end
      tests++;
      if ({W1, W2} !== {8'd1, 8'd1}) begin
         fails++; $display("FAIL empty_weights: W1=%0d W2=%0d required 1 1", W1, W2);
      end
      in_valid = 1'b1; in_x1 = 3'd3; in_x2 = 3'd4; in_t = 1'b0; start = 1'b1;
      qx1.push_back(3'd3); qx2.push_back(3'd4); qt.push_back(1'b0);
      sb.push_back(model_run());
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL coincident_busy: got %0b required 1", busy); end
      drain_result("coincident");
      return_to_load();
   endtask

   task automatic test_reset_mid_train();
      exp_t dummy = '{w1: 8'd0, w2: 8'd0, conv: 1'b0, ep: 4'd0, cyc: 0};
      send(3'd1, 3'd1, 1'b1);
      send(3'd1, 3'd1, 1'b0);
      start_train(1'b0, dummy, 1'b0);
      repeat (5) @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %0b required 1", busy); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      qx1.delete(); qx2.delete(); qt.delete();
      tests++;
      if ({busy, done, converged, in_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL midrst_flags: busy/done/conv/ready=%b required 0001",
                  {busy, done, converged, in_ready});
      end
      tests++;
      if ({W1, W2} !== {8'd1, 8'd1}) begin
         fails++; $display("FAIL midrst_weights: W1=%0d W2=%0d required 1 1", W1, W2);
      end
      tests++;
      if (epoch_cnt !== 4'd0) begin fails++; $display("FAIL midrst_epoch: got %0d required 0", epoch_cnt); end
      repeat (2) @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL midrst_stays_load: busy=%0b required 0", busy); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_converge();
      test_nonseparable();
      test_full_buffer();
      test_start_empty();
      test_reset_mid_train();
      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
